gold_catch_arbiter: RTL

- Central catch controller for all gold/stone items on the field, shared by the left and right claws.
- Grants each claw at most one item and each item to at most one claw; resolves same-cycle contention fairly.
- Paces the pull-back with a weight-dependent step count, then retires the item and reports its score.
- Sits between the per-item hit detectors and the claw/score logic. Per-item sprite modules consume catch_l/catch_r/destroy instead of running private catch FSMs.

---
 rtl/gold_catch_arbiter.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/gold_catch_arbiter.sv
// gold_catch_arbiter: shared catch controller for the left and right claws.
// Each claw runs an IDLE/GRANT/PULL/DONE FSM. A fair priority bit settles
// same-cycle contention for one item. The pull-back is paced by a
// weight-dependent step count. When an item is retired it sets its sticky
// destroy bit, and a completed pull also reports the item's score.
module gold_catch_arbiter #(
  parameter int NUM_ITEMS    = 4,
  parameter int TICK_DIV     = 8000000,
  parameter int BASE_STEPS   = 20,
  parameter int WEIGHT_STEPS = 4
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   is_new_game_start,
  input  logic [NUM_ITEMS-1:0]   hit_l,
  input  logic [NUM_ITEMS-1:0]   hit_r,
  input  logic [3*NUM_ITEMS-1:0] item_weight,
  input  logic [8*NUM_ITEMS-1:0] item_value,
  input  logic                   is_explodel,
  input  logic                   is_exploder,
  output logic [NUM_ITEMS-1:0]   catch_l,
  output logic [NUM_ITEMS-1:0]   catch_r,
  output logic                   busy_l,
  output logic                   busy_r,
  output logic                   pull_step_l,
  output logic                   pull_step_r,
  output logic [NUM_ITEMS-1:0]   destroy,
  output logic                   score_valid_l,
  output logic                   score_valid_r,
  output logic [7:0]             score_add_l,
  output logic [7:0]             score_add_r
);

  localparam int IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    PULL  = 2'd2,
    DONE  = 2'd3
  } claw_state_t;

  // Index 0 is the left claw, index 1 is the right claw.
  claw_state_t          state_r       [2];
  claw_state_t          state_s       [2];
  logic [IW-1:0]        item_r        [2];
  logic [9:0]           target_r      [2];
  logic [9:0]           step_r        [2];
  logic [DW-1:0]        div_r         [2];
  logic [NUM_ITEMS-1:0] held_r        [2];
  logic [7:0]           score_add_r_a [2];
  logic [1:0]           abort_r;
  logic [1:0]           busy_r_a;
  logic [1:0]           pull_step_r_a;
  logic [1:0]           score_valid_r_a;
  logic [NUM_ITEMS-1:0] destroy_r;
  logic                 prio_r;

  logic [NUM_ITEMS-1:0] avail_s       [2];
  logic [IW:0]          cand_s        [2];
  logic [IW-1:0]        cand_idx_s    [2];
  logic [2:0]           weight_s      [2];
  logic [7:0]           value_s       [2];
  logic [1:0]           cand_vld_s;
  logic [1:0]           take_s;
  logic [1:0]           explode_s;
  logic [1:0]           wrap_s;
  logic [1:0]           last_step_s;
  logic                 contest_s;

  // Returns {valid, index} of the lowest set bit of vec.
  function automatic logic [IW:0] lowest_set(input logic [NUM_ITEMS-1:0] vec);
    logic [IW:0] res;
    res = {(IW+1){1'b0}};
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res = {1'b1, IW'(i)};
      end
    end
    return res;
  endfunction

  // One-hot encoding of an item index.
  function automatic logic [NUM_ITEMS-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_ITEMS-1:0] res;
    res = {NUM_ITEMS{1'b0}};
    res[idx] = 1'b1;
    return res;
  endfunction

  // Candidate selection, contention resolution and pull pacing flags.
  always_comb begin
    explode_s = {is_exploder, is_explodel};
    // An item held by the other claw or already retired is never a candidate.
    avail_s[0] = hit_l & ~destroy_r & ~held_r[1];
    avail_s[1] = hit_r & ~destroy_r & ~held_r[0];
    for (int c = 0; c < 2; c++) begin
      cand_s[c]      = lowest_set(avail_s[c]);
      cand_vld_s[c]  = cand_s[c][IW];
      cand_idx_s[c]  = cand_s[c][IW-1:0];
      weight_s[c]    = item_weight[3*int'(cand_idx_s[c]) +: 3];
      value_s[c]     = item_value[8*int'(cand_idx_s[c]) +: 8];
      wrap_s[c]      = (div_r[c] == DW'(TICK_DIV - 1));
      last_step_s[c] = ((step_r[c] + 10'd1) >= target_r[c]);
    end
    contest_s = (state_r[0] == IDLE) && (state_r[1] == IDLE) &&
                cand_vld_s[0] && cand_vld_s[1] &&
                (cand_idx_s[0] == cand_idx_s[1]);
    // prio_r = 0 favours the left claw, 1 favours the right claw.
    take_s[0] = (state_r[0] == IDLE) && cand_vld_s[0] && !(contest_s && prio_r);
    take_s[1] = (state_r[1] == IDLE) && cand_vld_s[1] && !(contest_s && !prio_r);
  end

  // Next-state logic for both claw FSMs.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      state_s[c] = state_r[c];
      case (state_r[c])
        IDLE: begin
          if (take_s[c]) state_s[c] = GRANT;
          else           state_s[c] = IDLE;
        end
        GRANT: begin
          if (explode_s[c]) state_s[c] = DONE;
          else              state_s[c] = PULL;
        end
        PULL: begin
          if (explode_s[c])                     state_s[c] = DONE;
          else if (wrap_s[c] && last_step_s[c]) state_s[c] = DONE;
          else                                  state_s[c] = PULL;
        end
        DONE:    state_s[c] = IDLE;
        default: state_s[c] = IDLE;
      endcase
    end
  end

  // State register for both claw FSMs.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) state_r[c] <= IDLE;
    end else if (is_new_game_start) begin
      for (int c = 0; c < 2; c++) state_r[c] <= IDLE;
    end else begin
      for (int c = 0; c < 2; c++) state_r[c] <= state_s[c];
    end
  end

  // Per-claw datapath: grant latching, pull divider/step count, registered outputs.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        item_r[c]        <= {IW{1'b0}};
        target_r[c]      <= 10'd0;
        step_r[c]        <= 10'd0;
        div_r[c]         <= {DW{1'b0}};
        held_r[c]        <= {NUM_ITEMS{1'b0}};
        score_add_r_a[c] <= 8'd0;
      end
      abort_r         <= 2'b00;
      busy_r_a        <= 2'b00;
      pull_step_r_a   <= 2'b00;
      score_valid_r_a <= 2'b00;
    end else if (is_new_game_start) begin
      for (int c = 0; c < 2; c++) begin
        item_r[c]        <= {IW{1'b0}};
        target_r[c]      <= 10'd0;
        step_r[c]        <= 10'd0;
        div_r[c]         <= {DW{1'b0}};
        held_r[c]        <= {NUM_ITEMS{1'b0}};
        score_add_r_a[c] <= 8'd0;
      end
      abort_r         <= 2'b00;
      busy_r_a        <= 2'b00;
      pull_step_r_a   <= 2'b00;
      score_valid_r_a <= 2'b00;
    end else begin
      for (int c = 0; c < 2; c++) begin
        pull_step_r_a[c]   <= 1'b0;
        score_valid_r_a[c] <= 1'b0;
        case (state_r[c])
          IDLE: begin
            if (take_s[c]) begin
              item_r[c]        <= cand_idx_s[c];
              target_r[c]      <= 10'(BASE_STEPS) + 10'(WEIGHT_STEPS) * {7'd0, weight_s[c]};
              score_add_r_a[c] <= value_s[c];
              held_r[c]        <= onehot(cand_idx_s[c]);
              busy_r_a[c]      <= 1'b1;
            end
          end
          GRANT: begin
            div_r[c]   <= {DW{1'b0}};
            step_r[c]  <= 10'd0;
            abort_r[c] <= explode_s[c];
          end
          PULL: begin
            abort_r[c] <= explode_s[c];
            if (!explode_s[c]) begin
              if (wrap_s[c]) begin
                div_r[c]         <= {DW{1'b0}};
                step_r[c]        <= step_r[c] + 10'd1;
                pull_step_r_a[c] <= 1'b1;
              end else begin
                div_r[c] <= div_r[c] + DW'(1);
              end
            end
          end
          DONE: begin
            held_r[c]          <= {NUM_ITEMS{1'b0}};
            busy_r_a[c]        <= 1'b0;
            score_valid_r_a[c] <= ~abort_r[c];
          end
          default: begin
            held_r[c]   <= {NUM_ITEMS{1'b0}};
            busy_r_a[c] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Shared state: fairness bit and sticky retirement mask.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      prio_r    <= 1'b0;
      destroy_r <= {NUM_ITEMS{1'b0}};
    end else if (is_new_game_start) begin
      prio_r    <= 1'b0;
      destroy_r <= {NUM_ITEMS{1'b0}};
    end else begin
      if (contest_s) prio_r <= ~prio_r;
      for (int c = 0; c < 2; c++) begin
        if (state_r[c] == DONE) destroy_r[item_r[c]] <= 1'b1;
      end
    end
  end

  assign catch_l       = held_r[0];
  assign catch_r       = held_r[1];
  assign busy_l        = busy_r_a[0];
  assign busy_r        = busy_r_a[1];
  assign pull_step_l   = pull_step_r_a[0];
  assign pull_step_r   = pull_step_r_a[1];
  assign destroy       = destroy_r;
  assign score_valid_l = score_valid_r_a[0];
  assign score_valid_r = score_valid_r_a[1];
  assign score_add_l   = score_add_r_a[0];
  assign score_add_r   = score_add_r_a[1];

endmodule
